// File: rtl/mul_job_sequencer.sv
// rtl/mul_job_sequencer.sv - operand FIFO, launch/capture FSM and timeout watchdog for a shift-add multiplier
module mul_job_sequencer #(
    parameter int NB      = 15,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 2 * NB
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NB-1:0]           in_a,
    input  logic [NB-1:0]           in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*NB-1:0]         out_product,
    output logic                    out_err,
    output logic                    mult_start,
    output logic [NB-1:0]           mult_a,
    output logic [NB-1:0]           mult_b,
    input  logic [2*NB-1:0]         mult_product,
    input  logic                    mult_ready,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = 2 * NB;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_ARM,
        S_WAIT,
        S_OUT
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [NB-1:0]   mult_a_q, mult_a_d;
    logic [NB-1:0]   mult_b_q, mult_b_d;
    logic [PW-1:0]   out_product_q, out_product_d;
    logic            out_valid_q, out_valid_d;
    logic            out_err_q, out_err_d;

    logic [NB-1:0]   mem_a_q [DEPTH];
    logic [NB-1:0]   mem_b_q [DEPTH];

    logic            full;
    logic            push;
    logic            pop;

    // No bypass: a pop in the same cycle never frees a slot for a push while full.
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = rst_n && !full;
    assign push     = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        out_product_d = out_product_q;
        out_valid_d   = out_valid_q;
        out_err_d     = out_err_q;
        pop           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_ARM;
            end
            S_ARM: begin
                // The multiplier's ready is stale until it has seen the start pulse.
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (mult_ready) begin
                    out_product_d = mult_product;
                    out_err_d     = 1'b0;
                    out_valid_d   = 1'b1;
                    state_d       = S_OUT;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    out_product_d = '0;
                    out_err_d     = 1'b1;
                    out_valid_d   = 1'b1;
                    state_d       = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = S_LAUNCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mult_a_d = mult_a_q;
        mult_b_d = mult_b_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            mult_a_d = mem_a_q[rd_ptr_q];
            mult_b_d = mem_b_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= in_a;
            mem_b_q[wr_ptr_q] <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            timer_q       <= '0;
            mult_a_q      <= '0;
            mult_b_q      <= '0;
            out_product_q <= '0;
            out_valid_q   <= 1'b0;
            out_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            timer_q       <= timer_d;
            mult_a_q      <= mult_a_d;
            mult_b_q      <= mult_b_d;
            out_product_q <= out_product_d;
            out_valid_q   <= out_valid_d;
            out_err_q     <= out_err_d;
        end
    end

    assign mult_start  = (state_q == S_LAUNCH);
    assign mult_a      = mult_a_q;
    assign mult_b      = mult_b_q;
    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;
    assign out_err     = out_err_q;
    assign count       = count_q;
    assign busy        = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_mul_job_sequencer.sv
// tb/tb_mul_job_sequencer.sv - directed self-checking bench for mul_job_sequencer
module tb_mul_job_sequencer;

    localparam int NB      = 15;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 2 * NB;
    localparam int PW      = 2 * NB;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NB-1:0] in_a = '0;
    logic [NB-1:0] in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] out_product;
    logic          out_err;
    logic          mult_start;
    logic [NB-1:0] mult_a;
    logic [NB-1:0] mult_b;
    logic [PW-1:0] mult_product;
    logic          mult_ready;
    logic          busy;
    logic [CW-1:0] count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Multiplier stand-in: ready NB cycles after start; hang masks ready, force_rdy injects it.
    logic          hang = 1'b0;
    logic          force_rdy = 1'b0;
    int            m_cnt = 0;
    logic [PW-1:0] m_prod = '0;
    logic signed [PW-1:0] ea, eb;

    assign ea = {{NB{mult_a[NB-1]}}, mult_a};
    assign eb = {{NB{mult_b[NB-1]}}, mult_b};
    assign mult_ready   = force_rdy | (!hang && (m_cnt == 0));
    assign mult_product = m_prod;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mult_start) begin
            m_cnt  <= NB;
            m_prod <= ea * eb;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end

    mul_job_sequencer #(
        .NB(NB),
        .DEPTH(DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_product(out_product),
        .out_err(out_err),
        .mult_start(mult_start),
        .mult_a(mult_a),
        .mult_b(mult_b),
        .mult_product(mult_product),
        .mult_ready(mult_ready),
        .busy(busy),
        .count(count)
    );

    task automatic drive_push(input logic [NB-1:0] a, input logic [NB-1:0] b);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic drive_idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int max_cyc, output logic seen, output logic [PW-1:0] prod,
                              output logic err, output int vcyc);
        seen = 1'b0;
        prod = '0;
        err  = 1'b0;
        vcyc = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                prod = out_product;
                err  = out_err;
                vcyc = cyc;
                break;
            end
        end
    endtask

    task automatic wait_quiet(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_quiet: busy=%0b out_valid=%0b, required idle within 200 cycles", name, busy, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_a      = 15'd11;
        in_b      = 15'd12;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0)   begin n_bad++; $display("FAIL rst_in_ready: got %0b expected 0", in_ready); end
        n_cmp++; if (count !== '0)        begin n_bad++; $display("FAIL rst_count: got %0d expected 0", count); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        n_cmp++; if (mult_start !== 1'b0) begin n_bad++; $display("FAIL rst_mult_start: got %0b expected 0", mult_start); end
        n_cmp++; if (mult_a !== '0 || mult_b !== '0) begin n_bad++; $display("FAIL rst_mult_ab: got %0h/%0h expected 0/0", mult_a, mult_b); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_out_valid: got %0b expected 0", out_valid); end
        n_cmp++; if (out_err !== 1'b0)    begin n_bad++; $display("FAIL rst_out_err: got %0b expected 0", out_err); end
        n_cmp++; if (out_product !== '0)  begin n_bad++; $display("FAIL rst_out_product: got %0h expected 0", out_product); end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        int t, n_start, s_cyc, v_cyc;
        logic [PW-1:0] prod;
        logic err;
        out_ready = 1'b1;
        drive_push(15'd3, 15'd5);
        t = cyc;
        drive_idle();
        n_start = 0;
        s_cyc   = -1;
        v_cyc   = -1;
        prod    = '0;
        err     = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mult_start) begin
                n_start++;
                s_cyc = cyc;
            end
            if (out_valid && v_cyc < 0) begin
                v_cyc = cyc;
                prod  = out_product;
                err   = out_err;
            end
        end
        n_cmp++; if (n_start !== 1)          begin n_bad++; $display("FAIL lat_start_count: got %0d expected 1", n_start); end
        n_cmp++; if (s_cyc !== t + 2)        begin n_bad++; $display("FAIL lat_start_cycle: got %0d expected %0d", s_cyc, t + 2); end
        n_cmp++; if (v_cyc !== t + NB + 4)   begin n_bad++; $display("FAIL lat_valid_cycle: got %0d expected %0d", v_cyc, t + NB + 4); end
        n_cmp++; if (prod !== 30'd15)        begin n_bad++; $display("FAIL lat_product: got %0h expected f", prod); end
        n_cmp++; if (err !== 1'b0)           begin n_bad++; $display("FAIL lat_err: got %0b expected 0", err); end
        wait_quiet("lat");
    endtask

    task automatic test_signed();
        logic seen, err;
        logic [PW-1:0] prod;
        int vc;
        out_ready = 1'b1;
        drive_push(15'h7FFE, 15'd7);
        drive_idle();
        wait_valid(60, seen, prod, err, vc);
        n_cmp++; if (seen !== 1'b1 || prod !== 30'h3FFFFFF2) begin n_bad++; $display("FAIL sgn_neg_pos: got seen=%0b %0h expected 3ffffff2", seen, prod); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL sgn_neg_pos_err: got %0b expected 0", err); end
        wait_quiet("sgn1");
        drive_push(15'h7FFC, 15'h7FFA);
        drive_idle();
        wait_valid(60, seen, prod, err, vc);
        n_cmp++; if (seen !== 1'b1 || prod !== 30'd24) begin n_bad++; $display("FAIL sgn_neg_neg: got seen=%0b %0h expected 18", seen, prod); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL sgn_neg_neg_err: got %0b expected 0", err); end
        wait_quiet("sgn2");
    endtask

    task automatic test_backpressure();
        int accepted, k;
        logic expect_start, seen, err;
        logic [PW-1:0] prod;
        int vc;
        out_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 10; i++) begin
            drive_push(NB'(i + 1), 15'd1);
            @(negedge clk);
            if (in_ready) accepted++;
        end
        drive_idle();
        @(negedge clk);
        n_cmp++; if (accepted !== DEPTH + 1) begin n_bad++; $display("FAIL bp_accepted: got %0d expected %0d", accepted, DEPTH + 1); end
        n_cmp++; if (count !== CW'(DEPTH) || in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full: got count=%0d in_ready=%0b expected 4/0", count, in_ready); end
        wait_valid(60, seen, prod, err, vc);
        repeat (3) @(posedge clk);
        #1;
        out_ready    = 1'b1;
        k            = 0;
        expect_start = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (expect_start) begin
                expect_start = 1'b0;
                n_cmp++;
                if (mult_start !== 1'b1) begin n_bad++; $display("FAIL bp_relaunch_%0d: got mult_start=%0b expected 1", k, mult_start); end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (out_product !== PW'(k + 1) || out_err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bp_result_%0d: got %0h err=%0b expected %0h err=0", k, out_product, out_err, k + 1);
                end
                if (k < DEPTH) expect_start = 1'b1;
                k++;
            end
            if (k == DEPTH + 1 && !expect_start) break;
        end
        n_cmp++; if (k !== DEPTH + 1) begin n_bad++; $display("FAIL bp_result_count: got %0d expected %0d", k, DEPTH + 1); end
        wait_quiet("bp");
    endtask

    task automatic test_timeout();
        int l1, v1, l2, v2;
        logic [PW-1:0] p1, p2;
        logic e1, e2;
        out_ready = 1'b1;
        hang      = 1'b1;
        drive_push(15'd9, 15'd9);
        drive_push(15'd2, 15'd3);
        drive_idle();
        l1 = -1; v1 = -1; l2 = -1; v2 = -1;
        p1 = '1; p2 = '0; e1 = 1'b0; e2 = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (mult_start) begin
                if (l1 < 0) l1 = cyc;
                else if (l2 < 0) l2 = cyc;
            end
            if (out_valid) begin
                if (v1 < 0) begin
                    v1 = cyc; p1 = out_product; e1 = out_err;
                    hang = 1'b0;
                end else if (v2 < 0) begin
                    v2 = cyc; p2 = out_product; e2 = out_err;
                end
            end
            if (v2 >= 0) break;
        end
        hang = 1'b0;
        n_cmp++; if (v1 !== l1 + 2 + TIMEOUT) begin n_bad++; $display("FAIL to_valid_cycle: got %0d expected %0d", v1, l1 + 2 + TIMEOUT); end
        n_cmp++; if (e1 !== 1'b1) begin n_bad++; $display("FAIL to_err: got %0b expected 1", e1); end
        n_cmp++; if (p1 !== '0)   begin n_bad++; $display("FAIL to_product: got %0h expected 0", p1); end
        n_cmp++; if (l2 !== v1 + 1) begin n_bad++; $display("FAIL to_next_launch: got %0d expected %0d", l2, v1 + 1); end
        n_cmp++; if (p2 !== 30'd6 || v2 < 0) begin n_bad++; $display("FAIL to_next_product: got %0h expected 6", p2); end
        n_cmp++; if (e2 !== 1'b0) begin n_bad++; $display("FAIL to_next_err: got %0b expected 0", e2); end
        wait_quiet("to");
    endtask

    task automatic test_ready_race();
        logic found;
        int early;
        out_ready = 1'b1;
        hang      = 1'b1;
        drive_push(15'd5, 15'd6);
        drive_idle();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mult_start) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL race_launch: got %0b expected 1", found); end
        @(posedge clk);
        #1;
        force_rdy = 1'b1;
        @(posedge clk);
        #1;
        force_rdy = 1'b0;
        early = 0;
        for (int j = 0; j < TIMEOUT - 1; j++) begin
            @(negedge clk);
            if (out_valid) early++;
            @(posedge clk);
            #1;
        end
        force_rdy = 1'b1;
        @(negedge clk);
        if (out_valid) early++;
        @(posedge clk);
        #1;
        force_rdy = 1'b0;
        @(negedge clk);
        n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL race_arm_ignored: got %0d early valid cycles expected 0", early); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL race_valid: got %0b expected 1", out_valid); end
        n_cmp++; if (out_err !== 1'b0 || out_product !== 30'd30) begin n_bad++; $display("FAIL race_capture_wins: got err=%0b %0h expected err=0 1e", out_err, out_product); end
        hang = 1'b0;
        wait_quiet("race");
    endtask

    task automatic test_reset_midop();
        int stale;
        out_ready = 1'b1;
        hang      = 1'b1;
        drive_push(15'd1, 15'd2);
        drive_push(15'd3, 15'd4);
        drive_push(15'd5, 15'd6);
        drive_idle();
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_in_ready: got %0b expected 0", in_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL mid_busy: got %0b expected 0", busy); end
        n_cmp++; if (count !== '0)        begin n_bad++; $display("FAIL mid_count: got %0d expected 0", count); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL mid_out_valid: got %0b expected 0", out_valid); end
        n_cmp++; if (mult_start !== 1'b0) begin n_bad++; $display("FAIL mid_mult_start: got %0b expected 0", mult_start); end
        hang  = 1'b0;
        stale = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid || mult_start) stale++;
        end
        n_cmp++; if (stale !== 0) begin n_bad++; $display("FAIL mid_no_stale: got %0d active cycles expected 0", stale); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_signed();
        test_backpressure();
        test_timeout();
        test_ready_race();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
